// File: rtl/flag_pkg.sv
// Shared definitions for flag_player: move encodings, player FSM states,
// flag game state constants and the fixed autoplay script.
package flag_pkg;

    localparam logic [1:0] MOVE_IDLE    = 2'b00;
    localparam logic [1:0] MOVE_SECURE  = 2'b01;
    localparam logic [1:0] MOVE_RISK    = 2'b10;
    localparam logic [1:0] MOVE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        P_IDLE    = 2'd0,
        P_DRIVE   = 2'd1,
        P_CHECK   = 2'd2,
        P_RECOVER = 2'd3
    } player_state_e;

    localparam logic [2:0] FLAG_S0   = 3'd0;
    localparam logic [2:0] FLAG_S1   = 3'd1;
    localparam logic [2:0] FLAG_S2   = 3'd2;
    localparam logic [2:0] FLAG_S3   = 3'd3;
    localparam logic [2:0] FLAG_S4   = 3'd4;
    localparam logic [2:0] FLAG_LOSS = 3'd5;

    // Entry 0 sits in the least significant bits.
    localparam int         SCRIPT_LEN      = 5;
    localparam logic [2:0] SCRIPT_LAST     = 3'(SCRIPT_LEN - 1);
    localparam logic [9:0] AUTOPLAY_SCRIPT = {MOVE_SECURE, MOVE_SECURE, MOVE_SECURE,
                                              MOVE_RISK, MOVE_SECURE};

    function automatic logic [1:0] script_move(input logic [2:0] idx);
        logic [1:0] m;
        case (idx)
            3'd0:    m = AUTOPLAY_SCRIPT[1:0];
            3'd1:    m = AUTOPLAY_SCRIPT[3:2];
            3'd2:    m = AUTOPLAY_SCRIPT[5:4];
            3'd3:    m = AUTOPLAY_SCRIPT[7:6];
            3'd4:    m = AUTOPLAY_SCRIPT[9:8];
            default: m = MOVE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_player_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/flag_player.sv
// Move transmitter for the flag game FSM with saturating win/loss tallies.
// Optional scripted autoplay is enabled by defining FLAG_AUTOPLAY_EN.
module flag_player
    import flag_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int RECOVER_CYC = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_move,
    output logic             cmd_ready,
    output logic             secure,
    output logic             risk,
    input  logic             Win,
    input  logic             Loss,
    output logic             win_pulse,
    output logic             loss_pulse,
    output logic             cmd_err,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] loss_cnt,
`ifdef FLAG_AUTOPLAY_EN
    input  logic             auto_start,
`endif
    output logic [1:0]       dbg_state
);

    localparam int               REC_W   = $clog2(RECOVER_CYC + 1);
    localparam logic [REC_W-1:0] REC_MAX = REC_W'(RECOVER_CYC);

    player_state_e    state_q, state_d;
    logic             secure_q, secure_d;
    logic             risk_q, risk_d;
    logic             err_q, err_d;
    logic             win_seen_q, win_seen_d;
    logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
    logic             load_en;
    logic [1:0]       load_move;
    logic             script_busy;

`ifdef FLAG_AUTOPLAY_EN
    logic       script_run_q, script_run_d;
    logic [2:0] script_idx_q, script_idx_d;

    assign script_busy = script_run_q | auto_start;
`else
    assign script_busy = 1'b0;
`endif

    // A command is only taken when it will actually be played: no pending
    // loss to recover from and no script owning the move lines.
    assign cmd_ready = (state_q == P_IDLE) && !Loss && !script_busy;

    always_comb begin
        state_d    = state_q;
        secure_d   = 1'b0;
        risk_d     = 1'b0;
        err_d      = 1'b0;
        win_seen_d = win_seen_q;
        rec_cnt_d  = '0;
        load_en    = 1'b0;
        load_move  = MOVE_IDLE;
`ifdef FLAG_AUTOPLAY_EN
        script_run_d = script_run_q;
        script_idx_d = script_idx_q;
`endif
        case (state_q)
            P_IDLE: begin
                if (Loss) begin
                    state_d = P_RECOVER;
                end
`ifdef FLAG_AUTOPLAY_EN
                else if (script_run_q) begin
                    load_en   = 1'b1;
                    load_move = script_move(script_idx_q);
                end else if (auto_start) begin
                    load_en      = 1'b1;
                    load_move    = script_move(3'd0);
                    script_run_d = 1'b1;
                    script_idx_d = 3'd0;
                end
`endif
                else if (cmd_valid) begin
                    load_en   = 1'b1;
                    load_move = cmd_move;
                end
            end
            P_DRIVE: begin
                win_seen_d = Win;
                state_d    = P_CHECK;
            end
            P_CHECK: begin
                state_d = Loss ? P_RECOVER : P_IDLE;
`ifdef FLAG_AUTOPLAY_EN
                if (script_run_q && !Loss) begin
                    if (script_idx_q == SCRIPT_LAST) begin
                        script_run_d = 1'b0;
                    end else begin
                        script_idx_d = script_idx_q + 3'd1;
                    end
                end
`endif
            end
            P_RECOVER: begin
`ifdef FLAG_AUTOPLAY_EN
                script_run_d = 1'b0;
`endif
                rec_cnt_d = rec_cnt_q;
                if (rec_cnt_q != REC_MAX) begin
                    rec_cnt_d = rec_cnt_q + REC_W'(1);
                end
                if ((rec_cnt_q == REC_MAX) && !Loss) begin
                    state_d = P_IDLE;
                end
            end
            default: state_d = P_IDLE;
        endcase

        if (load_en) begin
            state_d  = P_DRIVE;
            secure_d = (load_move == MOVE_SECURE);
            risk_d   = (load_move == MOVE_RISK);
            err_d    = (load_move == MOVE_ILLEGAL);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= P_IDLE;
            secure_q   <= 1'b0;
            risk_q     <= 1'b0;
            err_q      <= 1'b0;
            win_seen_q <= 1'b0;
            rec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            secure_q   <= secure_d;
            risk_q     <= risk_d;
            err_q      <= err_d;
            win_seen_q <= win_seen_d;
            rec_cnt_q  <= rec_cnt_d;
        end
    end

`ifdef FLAG_AUTOPLAY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            script_run_q <= 1'b0;
            script_idx_q <= 3'd0;
        end else begin
            script_run_q <= script_run_d;
            script_idx_q <= script_idx_d;
        end
    end
`endif

    assign secure     = secure_q;
    assign risk       = risk_q;
    assign cmd_err    = (state_q == P_DRIVE) && err_q;
    assign win_pulse  = (state_q == P_CHECK) && win_seen_q;
    assign loss_pulse = (state_q == P_CHECK) && Loss;
    assign dbg_state  = state_q;

    logic cnt_clr;
    assign cnt_clr = !reset_n;

    sat_counter #(.WIDTH(CNT_W)) u_win_cnt (
        .clk   (clk),
        .clr   (cnt_clr),
        .inc   (win_pulse),
        .count (win_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_loss_cnt (
        .clk   (clk),
        .clr   (cnt_clr),
        .inc   (loss_pulse),
        .count (loss_cnt)
    );

endmodule

// File: doc/flag_player.md
# flag_player

Command-driven move transmitter for the `flag` game FSM: accepts one move per handshake, drives the registered `secure`/`risk` inputs of `flag` for exactly one cycle, then observes `Win`/`Loss` and keeps saturating win/loss tallies. After a loss it holds both move lines low until `flag` leaves its loss state, so every new game starts from the start state. Sits between the player input logic (buttons or test sequencer) and `flag`.

## Interface
- `CNT_W`, 8: width of `win_cnt`/`loss_cnt`.
- `RECOVER_CYC`, 1: minimum idle cycles driven after a loss (≥1).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  move command present.
- `cmd_move`  in  2  01 = secure, 10 = risk, 00 = idle move, 11 = illegal.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `secure`  out  1  to `flag.secure`, registered.
- `risk`  out  1  to `flag.risk`, registered.
- `Win`  in  1  from `flag`.
- `Loss`  in  1  from `flag`.
- `win_pulse`  out  1  one-cycle pulse per win.
- `loss_pulse`  out  1  one-cycle pulse per loss entry.
- `cmd_err`  out  1  one-cycle pulse when an illegal move is accepted.
- `win_cnt`  out  CNT_W  saturating win count.
- `loss_cnt`  out  CNT_W  saturating loss count.

## Operation
- States: IDLE, DRIVE, CHECK, RECOVER. Reset → IDLE.
- Reset values: `secure`=`risk`=0, pulses 0, counters 0. `cmd_ready`=1 in IDLE, 0 in all other states.
- IDLE: on handshake, register move into `secure`/`risk` → DRIVE. Move 11 drives both 0 and pulses `cmd_err` in the DRIVE cycle.
- DRIVE: move lines held for this cycle only. Sample `Win` here. → CHECK; `secure`/`risk` return to 0.
- CHECK: sample `Loss`. Assert `win_pulse` if `Win` was sampled in DRIVE. If `Loss`=1, assert `loss_pulse` and go → RECOVER. Otherwise go → IDLE.
- RECOVER: drive 0/0. Leave for IDLE when at least RECOVER_CYC cycles have elapsed and `Loss`=0 is sampled.
- Counters increment on their pulse and saturate at 2^CNT_W−1; they never wrap.
- `Loss` seen in IDLE (external corruption): enter RECOVER without a pulse or count.
- Synchronous reset in any state: return to IDLE, drop any in-flight move, clear counters.

## Timing
- Handshake at cycle T → move lines high at T+1 → pulses and counter update visible at T+2/T+3 → `cmd_ready` high again at T+3.
- Throughput: one move per 3 cycles when there is no loss.
- Loss path: with `RECOVER_CYC`=1 and a conforming `flag`, `cmd_ready` returns at T+5.
- `cmd_move` is sampled only on the handshake cycle. It may change freely at all other times.

## Configuration
- `FLAG_AUTOPLAY_EN` defined: adds input port `auto_start`. A pulse in IDLE plays the fixed script secure, risk, secure, secure, secure, using normal DRIVE/CHECK timing per move. `cmd_ready` is held low for the whole script.
- On any loss mid-script, the script aborts → RECOVER → IDLE.
- If `auto_start` and `cmd_valid` are both high in IDLE, `auto_start` wins.
- `FLAG_AUTOPLAY_EN` undefined: the `auto_start` port and the script ROM are absent; behaviour is command-only.

## Structure
- Shared package `flag_pkg`:
  - move encodings MOVE_IDLE/SECURE/RISK/ILLEGAL;
  - player state enum;
  - the `flag` state constants;
  - the 5-entry autoplay script constant.
- Sub-module `sat_counter` (parameter width, inputs `inc`/`clr`, output `count`), instantiated twice for the win and loss counts.

## Test plan
- Reset, then commands secure, risk, secure, secure, secure into a behavioural `flag` → `win_pulse` once, after the 5th move; `win_cnt`=1, `loss_cnt`=0, `flag` in S1.
- From S0 issue risk → `loss_pulse` in CHECK, `loss_cnt`=1; `cmd_ready` low until `Loss` clears, then high; `flag` in S0.
- Parameter `CNT_W`=2, repeat the winning pattern 5 times → `win_cnt` sticks at 3.
- Handshake with `cmd_move`=11 → `secure`=`risk`=0, `cmd_err` pulses once; no counter change.
- Assert `reset_n`=0 during DRIVE with secure high → next cycle `secure`=0, state IDLE, counters 0, `cmd_ready`=1.
- With `FLAG_AUTOPLAY_EN`: pulse `auto_start` with `cmd_valid`=1 → script runs, command ignored, `win_cnt`=1 after 15 cycles.
